fetch_queue: RTL and testbench

Parametrised decoupled instruction-fetch front end for the pipelined successor core. It owns the fetch PC and issues in-order requests to a variable-latency instruction memory. Returned instructions are buffered with their PCs in a DEPTH-entry FIFO that feeds decode. A redirect flushes the FIFO and discards stale in-flight responses, so decode can stall and the execute stage can resteer without losing or duplicating instructions.

---
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue.sv | 117 +++++++++++
 tb/tb_fetch_queue.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: imem request/response, execute resteer and decode-side queue head.
// master = fetch_queue, slave = surrounding pipeline and instruction memory.
interface fetch_queue_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              imem_req_o;
    logic [AWIDTH-1:0] imem_addr_o;
    logic              imem_rvalid_i;
    logic [DWIDTH-1:0] imem_rdata_i;
    logic              redirect_i;
    logic [AWIDTH-1:0] redirect_pc_i;
    logic              insn_valid_o;
    logic              insn_ready_i;
    logic [DWIDTH-1:0] insn_o;
    logic [AWIDTH-1:0] pc_o;
    logic [CW-1:0]     count_o;

    modport master (
        output imem_req_o, imem_addr_o, insn_valid_o, insn_o, pc_o, count_o,
        input  imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, insn_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, insn_valid_o, insn_o, pc_o, count_o,
        output imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, insn_ready_i
    );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled fetch: owns fetch PC, issues in-order imem requests, queues {pc, insn} for decode.
// Latency: request N, response N+1, head valid N+2. Backpressure: requests stop when queued + outstanding reaches DEPTH.
// Optional FETCHQ_ECALL_HALT_EN: an enqueued ecall stops further requests until redirect or reset.
module fetch_queue #(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 'h0100_0000,
    parameter int                DEPTH    = 4,
    parameter int                MAXLAT   = 8
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master bus
);
    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAXLAT < 1) begin : g_param_check
        $error("fetch_queue: DEPTH must be a power of two >= 2 and MAXLAT >= 1");
    end

    logic [AWIDTH-1:0] fetch_pc;
    logic [AWIDTH-1:0] q_pc   [DEPTH];
    logic [DWIDTH-1:0] q_insn [DEPTH];
    logic [AWIDTH-1:0] tag_pc [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr, tag_rd, tag_wr;
    logic [CW-1:0]     count, outstanding, drop_cnt;
    logic [CW:0]       inflight;
    logic              halt_blk;
    logic              req, resp, drop, push, pop;

`ifdef FETCHQ_ECALL_HALT_EN
    logic halted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted <= 1'b0;
        end else if (bus.redirect_i) begin
            halted <= 1'b0;
        end else if (push && bus.imem_rdata_i == DWIDTH'(32'h0000_0073)) begin
            halted <= 1'b1;
        end
    end

    assign halt_blk = halted;
`else
    assign halt_blk = 1'b0;
`endif

    // Outstanding includes responses already marked for discard, so the cap also bounds drop_cnt.
    always_comb begin
        inflight = {1'b0, count} + {1'b0, outstanding};
        req      = rst && !bus.redirect_i && !halt_blk && (inflight < CAP);
        resp     = bus.imem_rvalid_i && (outstanding != '0);
        drop     = resp && (drop_cnt != '0);
        push     = resp && !drop && !bus.redirect_i;
        pop      = (count != '0) && bus.insn_ready_i && !bus.redirect_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= BASEADDR;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (bus.redirect_i) begin
            // Everything still in flight is stale, including a response landing right now.
            fetch_pc    <= {bus.redirect_pc_i[AWIDTH-1:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(resp);
            drop_cnt    <= outstanding - CW'(resp);
        end else begin
            if (req) begin
                fetch_pc <= fetch_pc + AWIDTH'(4);
                tag_wr   <= tag_wr + PW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                tag_rd <= tag_rd + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            outstanding <= outstanding + CW'(req) - CW'(resp);
            count       <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (req) begin
            tag_pc[tag_wr] <= fetch_pc;
        end
        if (push) begin
            q_pc[wr_ptr]   <= tag_pc[tag_rd];
            q_insn[wr_ptr] <= bus.imem_rdata_i;
        end
    end

    assign bus.imem_req_o   = req;
    assign bus.imem_addr_o  = fetch_pc;
    assign bus.insn_valid_o = (count != '0);
    assign bus.insn_o       = (count != '0) ? q_insn[rd_ptr] : '0;
    assign bus.pc_o         = (count != '0) ? q_pc[rd_ptr] : '0;
    assign bus.count_o      = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: imem latency model plus a scoreboard of expected {pc, insn} per request.
module tb_fetch_queue;
    localparam int          AW     = 32;
    localparam int          DW     = 32;
    localparam int          DEPTH  = 4;
    localparam int          MAXLAT = 8;
    localparam logic [31:0] BASE   = 32'h0100_0000;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .AWIDTH(AW), .DWIDTH(DW), .BASEADDR(BASE), .DEPTH(DEPTH), .MAXLAT(MAXLAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    resp_t       pending[$];
    exp_t        sb[$];
    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    int          lat        = 1;
    int          req_total  = 0;
    logic        rdy        = 1'b0;
    logic        ecall_on   = 1'b0;
    logic [31:0] model_pc;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (ecall_on && a == 32'h0100_000C) return 32'h0000_0073;
        return {a[23:0], 8'h13} ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs change on the falling edge, outputs sampled before the next rising edge.
    task automatic drive(input logic rd, input logic [31:0] rpc, input logic ready);
        @(negedge clk);
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
        bus.insn_ready_i  = ready;
        #3;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (bus.imem_req_o) found = 1;
            else drive(1'b0, 32'h0, rdy);
        end
        check({tag, "_seen"}, found, 1);
        if (found != 0) check({tag, "_addr"}, bus.imem_addr_o, exp_addr);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
        int found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (bus.insn_valid_o) found = 1;
            else drive(1'b0, 32'h0, rdy);
        end
        check({tag, "_seen"}, found, 1);
        if (found != 0) check({tag, "_pc"}, bus.pc_o, exp_pc);
    endtask

    // Instruction memory and scoreboard: acts on what the DUT commits at the coming rising edge.
    initial begin
        resp_t r;
        exp_t  e;
        model_pc          = BASE;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            if (rst && pending.size() != 0 && pending[0].due <= cyc) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = pending[0].data;
            end else begin
                bus.imem_rvalid_i = 1'b0;
                bus.imem_rdata_i  = '0;
            end
            #2;
            if (!rst) begin
                pending.delete();
                sb.delete();
                model_pc = BASE;
            end else begin
                if (bus.imem_rvalid_i) void'(pending.pop_front());
                if (bus.redirect_i) begin
                    check("req_in_redirect", bus.imem_req_o, 0);
                    sb.delete();
                    model_pc = {bus.redirect_pc_i[31:2], 2'b00};
                end else begin
                    if (bus.imem_req_o) begin
                        req_total++;
                        check("req_addr", bus.imem_addr_o, model_pc);
                        r.due  = cyc + lat;
                        r.data = mem(model_pc);
                        pending.push_back(r);
                        e.pc   = model_pc;
                        e.insn = mem(model_pc);
                        sb.push_back(e);
                        model_pc += 32'd4;
                    end
                    if (bus.insn_valid_o && bus.insn_ready_i) begin
                        check("sb_nonempty", sb.size() != 0, 1);
                        if (sb.size() != 0) begin
                            check("pop_pc", bus.pc_o, sb[0].pc);
                            check("pop_insn", bus.insn_o, sb[0].insn);
                            void'(sb.pop_front());
                        end
                    end
                end
                if (!bus.insn_valid_o) begin
                    check("idle_pc", bus.pc_o, 0);
                    check("idle_insn", bus.insn_o, 0);
                end
            end
            cyc++;
        end
    end

    initial begin
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.insn_ready_i  = 1'b0;
        #12;
        check("rst_req", bus.imem_req_o, 0);
        check("rst_valid", bus.insn_valid_o, 0);
        check("rst_insn", bus.insn_o, 0);
        check("rst_pc", bus.pc_o, 0);
        check("rst_count", bus.count_o, 0);

        // Stalled decode: exactly DEPTH requests, then back-pressure.
        lat = 1;
        rdy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #3;
        wait_req("first_req", BASE);
        drive(1'b0, 32'h0, rdy);
        check("valid_n1", bus.insn_valid_o, 0);
        drive(1'b0, 32'h0, rdy);
        check("valid_n2", bus.insn_valid_o, 1);
        check("valid_n2_pc", bus.pc_o, BASE);
        check("valid_n2_insn", bus.insn_o, mem(BASE));
        repeat (10) drive(1'b0, 32'h0, rdy);
        check("stall_req_total", req_total, 4);
        check("stall_count", bus.count_o, 4);
        check("stall_req", bus.imem_req_o, 0);

        // Drain and refetch.
        rdy = 1'b1;
        drive(1'b0, 32'h0, rdy);
        wait_req("refetch", 32'h0100_0010);
        repeat (12) drive(1'b0, 32'h0, rdy);

        // Longer latency, resteer with stale responses in flight.
        lat = 3;
        repeat (12) drive(1'b0, 32'h0, rdy);
        drive(1'b1, 32'h0100_0103, rdy);
        drive(1'b0, 32'h0, rdy);
        check("redir_flush_count", bus.count_o, 0);
        wait_req("redir_req", 32'h0100_0100);
        wait_valid("redir_first", 32'h0100_0100);

        // Redirect landing on a response, then a second redirect right after.
        wait_req("pre_b2b", model_pc);
        drive(1'b0, 32'h0, rdy);
        drive(1'b0, 32'h0, rdy);
        drive(1'b1, 32'h0100_0200, rdy);
        drive(1'b1, 32'h0100_0300, rdy);
        drive(1'b0, 32'h0, rdy);
        wait_req("b2b_req", 32'h0100_0300);
        wait_valid("b2b_first", 32'h0100_0300);
        rdy = 1'b0;
        repeat (15) drive(1'b0, 32'h0, rdy);
        check("b2b_full_count", bus.count_o, 4);
        check("b2b_full_req", bus.imem_req_o, 0);

        // Asynchronous reset with three entries queued.
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        check("pre_rst_count", bus.count_o, 3);
        #1;
        rst = 1'b0;
        #1;
        check("arst_req", bus.imem_req_o, 0);
        check("arst_valid", bus.insn_valid_o, 0);
        check("arst_insn", bus.insn_o, 0);
        check("arst_pc", bus.pc_o, 0);
        check("arst_count", bus.count_o, 0);
        repeat (2) drive(1'b0, 32'h0, rdy);
        lat = 1;
        rdy = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        bus.insn_ready_i = rdy;
        #3;
        wait_req("rst_restart", BASE);
        repeat (10) drive(1'b0, 32'h0, rdy);

`ifdef FETCHQ_ECALL_HALT_EN
        ecall_on = 1'b1;
        drive(1'b1, BASE, rdy);
        repeat (15) drive(1'b0, 32'h0, rdy);
        check("halt_req", bus.imem_req_o, 0);
        check("halt_drained", bus.count_o, 0);
        drive(1'b1, BASE, rdy);
        drive(1'b0, 32'h0, rdy);
        wait_req("halt_resume", BASE);
        repeat (4) drive(1'b0, 32'h0, rdy);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
